// File: rtl/adc_acq_sequencer.sv
// ADC acquisition sequencer: paces conversions, strobes ADC convst/rd_n, pulses
// load, then waits for the serializer before the next frame. Flags overrun and busy timeout.
module adc_acq_sequencer #(
  parameter int unsigned SAMPLE_DIV   = 1000,
  parameter int unsigned CONV_PULSE   = 2,
  parameter int unsigned RD_CYCLES    = 3,
  parameter int unsigned BUSY_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear_err,
  input  logic             adc_busy,
  input  logic             ser_empty_tick,
  output logic             adc_convst,
  output logic             adc_rd_n,
  output logic             load,
  output logic [CNT_W-1:0] sample_count,
  output logic             overrun,
  output logic             timeout_err,
  output logic [2:0]       state
);

  localparam int unsigned DivW  = $clog2(SAMPLE_DIV);
  localparam int unsigned PhMax = (CONV_PULSE > RD_CYCLES) ?
                                  ((CONV_PULSE > BUSY_TIMEOUT) ? CONV_PULSE : BUSY_TIMEOUT) :
                                  ((RD_CYCLES > BUSY_TIMEOUT) ? RD_CYCLES : BUSY_TIMEOUT);
  localparam int unsigned PhW   = $clog2(PhMax + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StConv  = 3'd1,
    StWaitB = 3'd2,
    StRead  = 3'd3,
    StShift = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             convst_q, convst_d;
  logic             rd_n_q, rd_n_d;
  logic             load_q, load_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             sample_tick;
  logic             timeout_set;

  always_comb begin
    div_d = '0;
    if (enable && div_q != DivW'(SAMPLE_DIV - 1)) div_d = div_q + DivW'(1);
  end

  assign sample_tick = enable && (div_q == DivW'(SAMPLE_DIV - 1));

  always_comb begin
    state_d     = state_q;
    phase_d     = '0;
    count_d     = count_q;
    timeout_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (sample_tick) state_d = StConv;
      end
      StConv: begin
        if (phase_q == PhW'(CONV_PULSE - 1)) state_d = StWaitB;
        else                                 phase_d = phase_q + PhW'(1);
      end
      StWaitB: begin
        if (!adc_busy) begin
          state_d = StRead;
        end else if (phase_q == PhW'(BUSY_TIMEOUT - 1)) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StRead: begin
        if (phase_q == PhW'(RD_CYCLES - 1)) state_d = StShift;
        else                                phase_d = phase_q + PhW'(1);
      end
      StShift: begin
        if (ser_empty_tick) begin
          state_d = StIdle;
          count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes are decoded from the next state so they leave a flop directly.
    convst_d = (state_d == StConv);
    rd_n_d   = (state_d != StRead);
    load_d   = (state_d == StRead) && (phase_d == PhW'(RD_CYCLES - 1));

    // Setting a flag takes priority over clear_err in the same cycle.
    overrun_d = overrun_q;
    if (clear_err)                           overrun_d = 1'b0;
    if (sample_tick && state_q != StIdle)    overrun_d = 1'b1;
    timeout_d = timeout_q;
    if (clear_err)   timeout_d = 1'b0;
    if (timeout_set) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      phase_q   <= '0;
      count_q   <= '0;
      convst_q  <= 1'b0;
      rd_n_q    <= 1'b1;
      load_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      count_q   <= count_d;
      convst_q  <= convst_d;
      rd_n_q    <= rd_n_d;
      load_q    <= load_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign adc_convst   = convst_q;
  assign adc_rd_n     = rd_n_q;
  assign load         = load_q;
  assign sample_count = count_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_q;
  assign state        = state_q;

endmodule
